nihilist_encrypt_stream: RTL and testbench
==========================================

# nihilist_encrypt_stream

Streaming Nihilist-cipher encryptor: accepts plaintext characters one per handshake, maps each through the fixed 5x5 Polybius square (row-major: MATEI / BCDFG / HKLNO / PQRSU / VWXYZ), and emits the 8-bit sum of the character's and the current key character's two-digit codes. It is the transmit-side counterpart of the combinational decrypt block. Its output byte stream feeds that decryptor directly, which subtracts the same key codes. It adds valid/ready flow control, a message-framed key-index counter and a runtime-loadable key.

## Interface
- SEC_LEN, 9, key length in characters (1..16); reset key is "PARASCHIV" for SEC_LEN=9, first SEC_LEN chars of it (padded with "A") otherwise
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  plaintext character valid
- in_ready  out  1  block can accept a character
- in_char  in  8  ASCII plaintext character
- in_last  in  1  character is last of message
- out_valid  out  1  ciphertext byte valid
- out_ready  in  1  downstream accepts byte
- out_code  out  8  ciphertext value, binary (22..110 for valid input)
- out_last  out  1  byte is last of message
- out_err  out  1  input character had no square position
- key_we  in  1  key write strobe
- key_addr  in  4  key index to write
- key_data  in  8  ASCII key character
- busy  out  1  FSM in MSG state

## Operation
- Code of a character = row*10 + col, rows/cols 1..5 (e.g. M=11, A=12, Z=55). Only uppercase ASCII letters in the square are valid.
- FSM states: IDLE, MSG.
  - IDLE -> MSG on accepted char with in_last=0.
  - MSG -> IDLE on accepted char with in_last=1.
  - An accepted char with in_last=1 in IDLE stays in IDLE.
- Key index kidx (0..SEC_LEN-1):
  - Increments on every accepted char, wrapping SEC_LEN-1 -> 0.
  - Forced to 0 on accepted in_last.
- out_code = code(in_char) + code(key[kidx]), computed 8-bit unsigned; max 55+55=110, no overflow.
- Invalid char (no square position, including lowercase, digits and space):
  - out_code=8'h00, out_err=1.
  - kidx still advances, keeping key alignment with the decryptor.
- Invalid key entry: treated as code 0; the output is then flagged out_err=1.
- Key writes:
  - Honoured only in IDLE, only with key_addr < SEC_LEN, and only when no char is accepted in the same cycle.
  - Otherwise the write is silently dropped.
- out_last mirrors in_last of the corresponding input.

## Timing
- Reset values: in_ready=1, out_valid=0, out_code=0, out_last=0, out_err=0, busy=0. State=IDLE, kidx=0, key reloaded to default.
- Accept occurs when in_valid & in_ready. in_ready = !out_valid | out_ready (single output register, no skid buffer).
- Latency: one cycle. out_valid rises the cycle after accept. Full throughput of 1 char/cycle while out_ready=1.
- While out_valid & !out_ready: out_code, out_last and out_err are held stable, and in_ready=0.
- Key write takes effect for chars accepted from the next cycle on.
- Reset mid-message: the pending output is discarded and all state returns to reset values in the following cycle.

## Configuration
- NIHILIST_J_FOLD_EN defined: input 'J' is encoded as 'I' (code 15); 'J' is also accepted as a key character and folded to I.
- NIHILIST_J_FOLD_EN undefined: 'J' is invalid in both input and key, and produces out_code=0 with out_err=1.

## Test plan
- Default key, "ATTACK" (last on K), out_ready=1 -> 53,25,56,24,66,54 on consecutive cycles, out_last only on 54, busy drops after K.
- Ten 'M' in one message -> 52,23,54,23,55,33,42,26,62,52 (kidx wraps to P on the 10th character).
- "AT" then new message "A" -> 53,25 then 53 (kidx reset by in_last).
- out_ready held low 3 cycles after first output -> in_ready=0 and out_code=53 held stable, no character lost.
- Invalid input '1' at kidx 0 -> out_code=00, out_err=1; next input 'A' -> 24 (kidx advanced to key A).
- 'J' at kidx 0 -> 56 with NIHILIST_J_FOLD_EN, 00/err without. Key write key_addr=0 key_data "M" in IDLE, then 'A' -> 23. The same write issued during MSG is ignored.

Source files
------------

// File: rtl/nihilist_encrypt_stream.sv
// Streaming Nihilist-cipher encryptor: Polybius-square codes of plaintext and key summed per character.
// Optional J-to-I folding is selected with the NIHILIST_J_FOLD_EN macro.
module nihilist_encrypt_stream #(
  parameter int unsigned SEC_LEN = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_code,
  output logic       out_last,
  output logic       out_err,
  input  logic       key_we,
  input  logic [3:0] key_addr,
  input  logic [7:0] key_data,
  output logic       busy
);

  localparam int unsigned KEY_DEPTH = 16;
  localparam logic [3:0]  KIDX_MAX  = 4'(SEC_LEN - 1);

  typedef enum logic {IDLE, MSG} state_t;

  // Square position as row*10+col; zero marks a character outside the square.
  function automatic logic [7:0] sq_code(input logic [7:0] c);
    case (c)
      "M": sq_code = 8'd11;  "A": sq_code = 8'd12;  "T": sq_code = 8'd13;
      "E": sq_code = 8'd14;  "I": sq_code = 8'd15;
      "B": sq_code = 8'd21;  "C": sq_code = 8'd22;  "D": sq_code = 8'd23;
      "F": sq_code = 8'd24;  "G": sq_code = 8'd25;
      "H": sq_code = 8'd31;  "K": sq_code = 8'd32;  "L": sq_code = 8'd33;
      "N": sq_code = 8'd34;  "O": sq_code = 8'd35;
      "P": sq_code = 8'd41;  "Q": sq_code = 8'd42;  "R": sq_code = 8'd43;
      "S": sq_code = 8'd44;  "U": sq_code = 8'd45;
      "V": sq_code = 8'd51;  "W": sq_code = 8'd52;  "X": sq_code = 8'd53;
      "Y": sq_code = 8'd54;  "Z": sq_code = 8'd55;
`ifdef NIHILIST_J_FOLD_EN
      "J": sq_code = 8'd15;
`endif
      default: sq_code = 8'd0;
    endcase
  endfunction

  // Default key "PARASCHIV", padded with 'A' beyond its length.
  function automatic logic [7:0] def_key(input int unsigned i);
    case (i)
      0: def_key = "P";  1: def_key = "A";  2: def_key = "R";
      3: def_key = "A";  4: def_key = "S";  5: def_key = "C";
      6: def_key = "H";  7: def_key = "I";  8: def_key = "V";
      default: def_key = "A";
    endcase
  endfunction

  state_t     state;
  logic [3:0] kidx;
  logic [7:0] key [KEY_DEPTH];

  logic       accept;
  logic [7:0] char_code;
  logic [7:0] key_code;
  logic [7:0] sum_code;
  logic       sum_err;
  logic       key_wr_ok;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MSG);

  // Ciphertext for the character being offered this cycle.
  always_comb begin
    char_code = sq_code(in_char);
    key_code  = sq_code(key[kidx]);
    sum_err   = (char_code == 8'd0) || (key_code == 8'd0);
    sum_code  = 8'd0;
    if (char_code != 8'd0) sum_code = char_code + key_code;
    key_wr_ok = key_we && (state == IDLE) && !accept && (32'(key_addr) < SEC_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kidx      <= 4'd0;
      out_valid <= 1'b0;
      out_code  <= 8'd0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      for (int i = 0; i < KEY_DEPTH; i++) key[i] <= def_key(i);
    end else begin
      if (key_wr_ok) key[key_addr] <= key_data;

      if (accept) begin
        out_valid <= 1'b1;
        out_code  <= sum_code;
        out_last  <= in_last;
        out_err   <= sum_err;
        // Index restarts per message so the decryptor stays aligned.
        if (in_last || kidx == KIDX_MAX) kidx <= 4'd0;
        else                             kidx <= kidx + 4'd1;
        case (state)
          IDLE:    if (!in_last) state <= MSG;
          MSG:     if (in_last)  state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nihilist_encrypt_stream.sv
// Scoreboard bench for nihilist_encrypt_stream: driver queues expected bytes, monitor pops on handshake.
module tb_nihilist_encrypt_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_last;
  logic       out_err;
  logic       key_we;
  logic [3:0] key_addr;
  logic [7:0] key_data;
  logic       busy;

  typedef struct packed {
    logic [7:0] code;
    logic       last;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  nihilist_encrypt_stream #(.SEC_LEN(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_last(out_last), .out_err(out_err),
    .key_we(key_we), .key_addr(key_addr), .key_data(key_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got code %0d with empty queue", out_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_code", int'(out_code), int'(e.code));
        chk("out_last", int'(out_last), int'(e.last));
        chk("out_err",  int'(out_err),  int'(e.err));
      end
    end
  end

  // Offer one character until accepted; expected response is queued at issue time.
  task automatic send(input logic [7:0] c, input logic last, input logic [7:0] ecode, input logic eerr);
    logic acc;
    int   n;
    exp_q.push_back('{code: ecode, last: last, err: eerr});
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: char %0d not accepted", c);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_code", int'(out_code), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic key_write(input logic [3:0] a, input logic [7:0] d);
    key_we   = 1'b1;
    key_addr = a;
    key_data = d;
    @(posedge clk);
    #1;
    key_we = 1'b0;
  endtask

  logic [7:0] attack_c [6] = '{"A", "T", "T", "A", "C", "K"};
  logic [7:0] attack_e [6] = '{8'd53, 8'd25, 8'd56, 8'd24, 8'd66, 8'd54};
  logic [7:0] m_e [10] = '{8'd52, 8'd23, 8'd54, 8'd23, 8'd55, 8'd33, 8'd42, 8'd26, 8'd62, 8'd52};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_char = 8'd0; in_last = 1'b0;
    out_ready = 1'b1; key_we = 1'b0; key_addr = 4'd0; key_data = 8'd0;
    @(posedge clk);
    #1;
    do_reset();

    // ATTACK with the default key
    for (int i = 0; i < 6; i++) begin
      send(attack_c[i], (i == 5), attack_e[i], 1'b0);
      chk("attack_busy", int'(busy), (i == 5) ? 0 : 1);
    end
    drain();

    // Ten M characters, key index wraps back to P
    for (int i = 0; i < 10; i++) send("M", (i == 9), m_e[i], 1'b0);
    drain();

    // Key index restarts at a new message
    send("A", 1'b0, 8'd53, 1'b0);
    send("T", 1'b1, 8'd25, 1'b0);
    send("A", 1'b1, 8'd53, 1'b0);
    drain();

    // Backpressure: first output held while out_ready is low
    out_ready = 1'b0;
    send("A", 1'b0, 8'd53, 1'b0);
    fork
      send("T", 1'b1, 8'd25, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_out_code", int'(out_code), 53);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Invalid character still advances the key index
    send("1", 1'b0, 8'd0, 1'b1);
    send("A", 1'b1, 8'd24, 1'b0);
    drain();

    // J handling
`ifdef NIHILIST_J_FOLD_EN
    send("J", 1'b1, 8'd56, 1'b0);
`else
    send("J", 1'b1, 8'd0, 1'b1);
`endif
    drain();

    // Key write in IDLE is used by the next character
    key_write(4'd0, "M");
    send("A", 1'b0, 8'd23, 1'b0);
    chk("msg_busy", int'(busy), 1);
    // Write during MSG must be dropped
    key_write(4'd0, "P");
    send("A", 1'b1, 8'd24, 1'b0);
    send("A", 1'b1, 8'd23, 1'b0);
    drain();

    // Reset reloads the default key
    do_reset();
    send("A", 1'b1, 8'd53, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
